// File: rtl/dec_ec_pkg.sv
// rtl/dec_ec_pkg.sv - shared widths and consume record for the EC bit window aligner
package dec_ec_pkg;

    localparam int EC_IN_W   = 64;
    localparam int EC_WIN_W  = 128;
    localparam int EC_BUF_W  = 256;
    localparam int EC_CNT_W  = 24;
    localparam int EC_FILL_W = 9;
    localparam int EC_SIZE_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [EC_SIZE_W-1:0] bits;
    } consume_t;

endpackage

// File: rtl/dec_ec_bit_window_if.sv
// rtl/dec_ec_bit_window_if.sv - input word stream and decoder window/consume handshake
interface dec_ec_bit_window_if;
    import dec_ec_pkg::*;

    logic                 in_valid;
    logic [EC_IN_W-1:0]   in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 win_valid;
    logic [EC_WIN_W-1:0]  win_data;
    logic                 consume_valid;
    logic [EC_SIZE_W-1:0] consume_bits;

    modport master (
        output in_valid, in_data, in_last, consume_valid, consume_bits,
        input  in_ready, win_valid, win_data
    );

    modport slave (
        input  in_valid, in_data, in_last, consume_valid, consume_bits,
        output in_ready, win_valid, win_data
    );

endinterface

// File: rtl/dec_ec_lshift.sv
// rtl/dec_ec_lshift.sv - logarithmic left barrel shifter, zero fill
module dec_ec_lshift #(
    parameter int W    = 256,
    parameter int SH_W = 8
) (
    input  logic [W-1:0]    data,
    input  logic [SH_W-1:0] amt,
    output logic [W-1:0]    result
);

    logic [W-1:0] stage;

    always_comb begin
        stage = data;
        for (int i = 0; i < SH_W; i++) begin
            if (amt[i]) begin
                stage = stage << (1 << i);
            end
        end
    end

    assign result = stage;

endmodule

// File: rtl/dec_ec_bit_window.sv
// rtl/dec_ec_bit_window.sv - MSB-aligned bit window between substream FIFO and EC symbol decoder
module dec_ec_bit_window
    import dec_ec_pkg::*;
#(
    parameter int CNT_W = EC_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    dec_ec_bit_window_if.slave   bus,
    output logic [EC_FILL_W-1:0] fill_level,
    output logic [CNT_W-1:0]     bits_consumed,
    output logic                 eos,
    output logic                 err
);

    logic [EC_BUF_W-1:0]  bit_buf;
    logic [EC_BUF_W-1:0]  kept;
    logic [EC_BUF_W-1:0]  inserted;
    logic [EC_BUF_W-1:0]  in_ext;
    logic [EC_FILL_W-1:0] fill;
    logic [EC_FILL_W-1:0] rem;
    logic [EC_FILL_W-1:0] fill_next;
    logic [EC_SIZE_W-1:0] c;
    logic [EC_SIZE_W-1:0] ins_amt;
    logic                 last_seen;
    logic                 legal;
    logic                 accept;
    consume_t             cons;

    assign cons = '{valid: bus.consume_valid, bits: bus.consume_bits};

    assign bus.win_data  = bit_buf[EC_BUF_W-1 -: EC_WIN_W];
    assign bus.win_valid = (fill >= EC_FILL_W'(EC_WIN_W)) | (last_seen & (fill != '0));
    // Readiness looks only at registered fill so the consume path never feeds back into in_ready.
    assign bus.in_ready  = !last_seen & (fill <= EC_FILL_W'(EC_BUF_W - EC_IN_W));

    assign legal  = cons.valid & bus.win_valid & ({1'b0, cons.bits} <= fill);
    assign c      = legal ? cons.bits : '0;
    assign accept = bus.in_valid & bus.in_ready;

    assign rem       = fill - {1'b0, c};
    assign fill_next = rem + (accept ? EC_FILL_W'(EC_IN_W) : '0);
    // The new word lands directly below the bits that survive this cycle's consume.
    assign ins_amt   = EC_SIZE_W'(EC_FILL_W'(EC_BUF_W - EC_IN_W) - rem);
    assign in_ext    = {{(EC_BUF_W - EC_IN_W){1'b0}}, bus.in_data};

    dec_ec_lshift #(.W(EC_BUF_W), .SH_W(EC_SIZE_W)) u_consume_shift (
        .data   (bit_buf),
        .amt    (c),
        .result (kept)
    );

    dec_ec_lshift #(.W(EC_BUF_W), .SH_W(EC_SIZE_W)) u_insert_shift (
        .data   (in_ext),
        .amt    (ins_amt),
        .result (inserted)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bit_buf       <= '0;
            fill          <= '0;
            bits_consumed <= '0;
            last_seen     <= 1'b0;
            err           <= 1'b0;
        end else begin
            bit_buf       <= kept | (accept ? inserted : '0);
            fill          <= fill_next;
            bits_consumed <= bits_consumed + CNT_W'(c);
            if (accept && bus.in_last) begin
                last_seen <= 1'b1;
            end
            if (cons.valid && !legal) begin
                err <= 1'b1;
            end
        end
    end

    assign fill_level = fill;
    assign eos        = last_seen & (fill == '0);

endmodule

// File: tb/tb_dec_ec_bit_window.sv
// tb/tb_dec_ec_bit_window.sv - directed vector bench for dec_ec_bit_window
module tb_dec_ec_bit_window;

    typedef struct {
        logic         fl;
        logic         iv;
        logic [63:0]  d;
        logic         il;
        logic         cv;
        logic [7:0]   cb;
        logic [8:0]   e_fill;
        logic         e_wv;
        logic         e_rdy;
        logic [23:0]  e_bc;
        logic         e_eos;
        logic         e_err;
        logic         cw;
        logic [127:0] e_win;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [8:0]  fill_level;
    logic [23:0] bits_consumed;
    logic        eos;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vq[$];

    dec_ec_bit_window_if bus ();

    dec_ec_bit_window dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .bus           (bus),
        .fill_level    (fill_level),
        .bits_consumed (bits_consumed),
        .eos           (eos),
        .err           (err)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] W0 = 64'hFEDCBA9876543210;
    localparam logic [63:0] W1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] W2 = 64'hA5A5_0F0F_C3C3_1234;
    localparam logic [63:0] W3 = 64'h8000_0000_0000_0001;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [63:0] d, input logic il,
                                input logic cv, input logic [7:0] cb, input logic [8:0] f,
                                input logic wv, input logic rdy, input logic [23:0] bc,
                                input logic e_eos, input logic e_err, input logic cw,
                                input logic [127:0] w);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.il = il; v.cv = cv; v.cb = cb;
        v.e_fill = f; v.e_wv = wv; v.e_rdy = rdy; v.e_bc = bc;
        v.e_eos = e_eos; v.e_err = e_err; v.cw = cw; v.e_win = w;
        return v;
    endfunction

    task automatic drive(input logic fl, input logic iv, input logic [63:0] d, input logic il,
                         input logic cv, input logic [7:0] cb);
        flush = fl; bus.in_valid = iv; bus.in_data = d; bus.in_last = il;
        bus.consume_valid = cv; bus.consume_bits = cb;
        @(posedge clk);
        #1;
        flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.consume_valid = 1'b0; bus.consume_bits = '0;
    endtask

    task automatic check_state(input string tag, input logic [8:0] f, input logic wv, input logic rdy,
                               input logic [23:0] bc, input logic e_eos, input logic e_err);
        chk({tag, " fill"}, 128'(fill_level), 128'(f));
        chk({tag, " win_valid"}, 128'(bus.win_valid), 128'(wv));
        chk({tag, " in_ready"}, 128'(bus.in_ready), 128'(rdy));
        chk({tag, " bits_consumed"}, 128'(bits_consumed), 128'(bc));
        chk({tag, " eos"}, 128'(eos), 128'(e_eos));
        chk({tag, " err"}, 128'(err), 128'(e_err));
    endtask

    initial begin
        logic [127:0] a128;
        logic [255:0] full17;
        logic [255:0] full19;
        logic [255:0] bsim;
        logic [127:0] w;

        a128   = {W0, W1};
        full17 = ({W0, W1, W2, 64'h0} << 63) | ({192'h0, W3} << 63);
        full19 = full17 << 1;
        bsim   = ({W0, W1, W2, 64'h0} << 6) | ({192'h0, W3} << 6);

        //                fl iv  data  il cv  cb    fill wv rdy bc   eos err cw win
        vq.push_back(mk(0, 1, W0, 0, 0, 8'd0,   9'd64,  0, 1, 24'd0,   0, 0, 1, {W0, 64'h0}));
        vq.push_back(mk(0, 1, W1, 1, 0, 8'd0,   9'd128, 1, 0, 24'd0,   0, 0, 1, a128));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd14,  9'd114, 1, 0, 24'd14,  0, 0, 1, a128 << 14));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd14,  9'd100, 1, 0, 24'd28,  0, 0, 1, a128 << 28));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd14,  9'd86,  1, 0, 24'd42,  0, 0, 1, a128 << 42));
        vq.push_back(mk(0, 1, W2, 0, 0, 8'd0,   9'd86,  1, 0, 24'd42,  0, 0, 1, a128 << 42));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd87,  9'd86,  1, 0, 24'd42,  0, 1, 1, a128 << 42));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd86,  9'd0,   0, 0, 24'd128, 1, 1, 1, 128'h0));
        vq.push_back(mk(1, 1, W2, 0, 0, 8'd0,   9'd0,   0, 1, 24'd0,   0, 0, 1, 128'h0));
        vq.push_back(mk(0, 1, W2, 1, 0, 8'd0,   9'd64,  1, 0, 24'd0,   0, 0, 1, {W2, 64'h0}));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd44,  9'd20,  1, 0, 24'd44,  0, 0, 1, {W2, 64'h0} << 44));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd20,  9'd0,   0, 0, 24'd64,  1, 0, 1, 128'h0));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd1,   9'd0,   0, 0, 24'd64,  1, 1, 1, 128'h0));
        vq.push_back(mk(1, 0, 0,  0, 0, 8'd0,   9'd0,   0, 1, 24'd0,   0, 0, 1, 128'h0));
        vq.push_back(mk(0, 1, W0, 0, 0, 8'd0,   9'd64,  0, 1, 24'd0,   0, 0, 1, {W0, 64'h0}));
        vq.push_back(mk(0, 1, W1, 0, 0, 8'd0,   9'd128, 1, 1, 24'd0,   0, 0, 1, a128));
        vq.push_back(mk(0, 1, W2, 0, 0, 8'd0,   9'd192, 1, 1, 24'd0,   0, 0, 1, a128));
        vq.push_back(mk(0, 1, W3, 0, 1, 8'd63,  9'd193, 1, 0, 24'd63,  0, 0, 1, full17[255:128]));
        vq.push_back(mk(0, 1, W3, 0, 0, 8'd0,   9'd193, 1, 0, 24'd63,  0, 0, 1, full17[255:128]));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd1,   9'd192, 1, 1, 24'd64,  0, 0, 1, full19[255:128]));
        vq.push_back(mk(0, 1, W3, 0, 0, 8'd0,   9'd256, 1, 0, 24'd64,  0, 0, 1, full19[255:128]));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd128, 9'd128, 1, 1, 24'd192, 0, 0, 0, 128'h0));
        vq.push_back(mk(0, 0, 0,  0, 1, 8'd51,  9'd77,  0, 1, 24'd243, 0, 0, 0, 128'h0));
        vq.push_back(mk(1, 1, W1, 0, 0, 8'd0,   9'd0,   0, 1, 24'd0,   0, 0, 1, 128'h0));

        rst = 1'b1;
        flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.consume_valid = 1'b0; bus.consume_bits = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("reset", 9'd0, 1'b0, 1'b1, 24'd0, 1'b0, 1'b0);
        chk("reset win_data", bus.win_data, 128'h0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].fl, vq[i].iv, vq[i].d, vq[i].il, vq[i].cv, vq[i].cb);
            check_state($sformatf("v%0d", i), vq[i].e_fill, vq[i].e_wv, vq[i].e_rdy,
                        vq[i].e_bc, vq[i].e_eos, vq[i].e_err);
            if (vq[i].cw) begin
                chk($sformatf("v%0d win_data", i), bus.win_data, vq[i].e_win);
            end
        end

        // Accept and consume in the same cycle, then pull the new word up into the window.
        drive(0, 1, W0, 0, 0, 8'd0);
        drive(0, 1, W1, 0, 0, 8'd0);
        drive(0, 1, W2, 0, 0, 8'd0);
        check_state("sim pre", 9'd192, 1'b1, 1'b1, 24'd0, 1'b0, 1'b0);
        drive(0, 1, W3, 0, 1, 8'd6);
        check_state("sim both", 9'd250, 1'b1, 1'b0, 24'd6, 1'b0, 1'b0);
        w = bsim[255:128];
        chk("sim both win_data", bus.win_data, w);
        drive(0, 0, 0, 0, 1, 8'd128);
        check_state("sim pull", 9'd122, 1'b0, 1'b1, 24'd134, 1'b0, 1'b0);
        w = bsim[127:0];
        chk("sim pull win_data", bus.win_data, w);

        // Reset mid-stream behaves like flush.
        rst = 1'b1;
        drive(0, 1, W3, 1, 0, 8'd0);
        rst = 1'b0;
        check_state("rst mid", 9'd0, 1'b0, 1'b1, 24'd0, 1'b0, 1'b0);
        chk("rst mid win_data", bus.win_data, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
